// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the transmit (and future receive) path
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Even parity is the XOR of the data bits; odd parity is its complement.
    function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with a one-cycle bit_done pulse on the last cycle
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_done = !restart && (cnt_q == LAST);

    // Wrapping at LAST makes each following bit period start from zero without an explicit restart.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1/8E1/8O2-style UART transmitter with valid/ready byte input
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_line
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
    localparam logic       STOP_LAST = (STOP_BITS == 2);
    localparam logic       ODD_SENSE = (PARITY_ODD != 0);

    tx_state_t                   state_q, state_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic [2:0]                  idx_q, idx_d;
    logic                        stop_q, stop_d;
    logic                        par_q, par_d;
    logic                        line_q, line_d;
    logic                        bit_done;
    logic                        accept;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (state_q == IDLE),
        .bit_done(bit_done)
    );

    assign tx_ready = (state_q == IDLE) && !rst;
    assign tx_busy  = (state_q != IDLE);
    assign tx_line  = line_q;
    assign accept   = tx_valid && tx_ready;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        par_d   = par_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    shift_d = tx_data;
                    par_d   = calc_parity(tx_data, ODD_SENSE);
                    idx_d   = '0;
                    stop_d  = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == LAST_BIT) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    stop_d = 1'b1;
                    if (stop_q == STOP_LAST) begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line register follows the current state, so the start bit appears one edge after accept.
    always_comb begin
        line_d = UART_IDLE_LEVEL;
        case (state_q)
            START:   line_d = 1'b0;
            DATA:    line_d = shift_q[0];
            PARITY:  line_d = par_q;
            default: line_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            line_q  <= UART_IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            par_q   <= par_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic [2:0] valid;
    logic [2:0] ready;
    logic [2:0] busy;
    logic [2:0] line;

    int total;
    int bad;
    int cyc;
    int nfalls;
    int fall_last;
    int fall_prev;
    logic prev0;
    int run [3];
    int last_len [3];

    // 0: 8N1, 1: 8E2, 2: 8O1; all at 4 clocks per bit
    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx_busy(busy[0]), .tx_line(line[0]));
    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_e (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx_busy(busy[1]), .tx_line(line[1]));
    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_o (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx_busy(busy[2]), .tx_line(line[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0; nfalls = 0; fall_last = 0; fall_prev = 0; prev0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run[i] = 0;
            last_len[i] = 0;
        end
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (prev0 && !line[0]) begin
            fall_prev = fall_last;
            fall_last = cyc;
            nfalls    = nfalls + 1;
        end
        prev0 = line[0];
        for (int i = 0; i < 3; i++) begin
            if (busy[i]) begin
                run[i] = run[i] + 1;
            end else begin
                if (run[i] != 0) last_len[i] = run[i];
                run[i] = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_tx(input int w, input logic [7:0] d);
        int g;
        g = 0;
        @(negedge clk);
        while (!ready[w] && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("ready_wait", 32'(ready[w]), 32'd1);
        tx_data  = d;
        valid[w] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid[w] = 1'b0;
    endtask

    task automatic wait_fall(input int w, output int n);
        logic p;
        logic done;
        p = line[w];
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (p && !line[w]) done = 1'b1;
            else if (n >= 200) begin
                done = 1'b1;
                chk("fall_timeout", 32'(n), 32'd0);
            end
            p = line[w];
        end
    endtask

    task automatic grab(input int w, input int nb, output logic [15:0] bits);
        bits = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < nb; k++) begin
            bits[k] = line[w];
            if (k < nb - 1) repeat (4) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int w);
        int g;
        g = 0;
        while (busy[w] && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("idle_wait", 32'(busy[w]), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] bits;
        logic [15:0] exp;
        int n;
        int n0;
        int g;
        int lows;

        total = 0; bad = 0;
        rst = 1'b1; tx_data = 8'h00; valid = 3'b000;

        // power-on reset state
        @(negedge clk);
        chk("por_line", 32'(line), 32'h7);
        chk("por_ready", 32'(ready), 32'h0);
        chk("por_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("por_ready_rel", 32'(ready), 32'h7);

        // 1: async reset while idle with valid asserted
        tx_data = 8'hFF; valid[0] = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_line", 32'(line[0]), 32'd1);
        chk("rst_ready", 32'(ready[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_busy", 32'(busy[0]), 32'd0);
        valid[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_ready", 32'(ready[0]), 32'd1);
        chk("rst_rel_line", 32'(line[0]), 32'd1);

        // 2: single byte 0xA5, 8N1
        start_tx(0, 8'hA5);
        chk("a5_lat_hold", 32'(line[0]), 32'd1);
        chk("a5_busy", 32'(busy[0]), 32'd1);
        chk("a5_not_ready", 32'(ready[0]), 32'd0);
        wait_fall(0, n);
        chk("a5_latency", 32'(n), 32'd1);
        grab(0, 10, bits);
        exp = {6'b0, 1'b1, 8'hA5, 1'b0};
        chk("a5_frame", 32'(bits), 32'(exp));
        wait_idle(0);
        chk("a5_len", 32'(last_len[0]), 32'd40);
        chk("a5_idle_ready", 32'(ready[0]), 32'd1);

        // 3: back-to-back 0x00 then 0xFF with valid held
        @(negedge clk);
        tx_data = 8'h00; valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'hFF;
        n0 = nfalls;
        g = 0;
        while (nfalls < n0 + 2 && g < 150) begin
            @(negedge clk);
            g++;
        end
        valid[0] = 1'b0;
        chk("b2b_two_starts", 32'(nfalls - n0), 32'd2);
        chk("b2b_spacing", 32'(fall_last - fall_prev), 32'd41);
        chk("b2b_first_len", 32'(last_len[0]), 32'd40);
        wait_idle(0);

        // 4: parity, even with two stop bits and odd with one
        start_tx(1, 8'h07);
        wait_fall(1, n);
        grab(1, 12, bits);
        exp = {4'b0, 2'b11, 1'b1, 8'h07, 1'b0};
        chk("even_frame", 32'(bits), 32'(exp));
        chk("even_parity", 32'(bits[9]), 32'd1);
        wait_idle(1);
        chk("even_len", 32'(last_len[1]), 32'd48);

        start_tx(2, 8'h07);
        wait_fall(2, n);
        grab(2, 11, bits);
        exp = {5'b0, 1'b1, 1'b0, 8'h07, 1'b0};
        chk("odd_frame", 32'(bits), 32'(exp));
        chk("odd_parity", 32'(bits[9]), 32'd0);
        wait_idle(2);
        chk("odd_len", 32'(last_len[2]), 32'd44);

        // 5: new data presented mid-frame is held off until the frame completes
        @(negedge clk);
        tx_data = 8'hC3; valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'h3C;
        chk("hs_not_ready", 32'(ready[0]), 32'd0);
        wait_fall(0, n);
        grab(0, 10, bits);
        exp = {6'b0, 1'b1, 8'hC3, 1'b0};
        chk("hs_first_frame", 32'(bits), 32'(exp));
        wait_fall(0, n);
        valid[0] = 1'b0;
        grab(0, 10, bits);
        exp = {6'b0, 1'b1, 8'h3C, 1'b0};
        chk("hs_second_frame", 32'(bits), 32'(exp));
        wait_idle(0);

        // 6: reset during frame bit 4 of 0x55, then 0x81 goes out intact
        start_tx(0, 8'h55);
        wait_fall(0, n);
        repeat (18) @(negedge clk);
        chk("mid_line_low", 32'(line[0]), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_line", 32'(line[0]), 32'd1);
        chk("mid_rst_busy", 32'(busy[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!line[0] || busy[0]) lows++;
        end
        chk("mid_no_resume", 32'(lows), 32'd0);
        start_tx(0, 8'h81);
        wait_fall(0, n);
        grab(0, 10, bits);
        exp = {6'b0, 1'b1, 8'h81, 1'b0};
        chk("post_rst_frame", 32'(bits), 32'(exp));
        wait_idle(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
